// File: rtl/fp_regfile_sb_pkg.sv
// Shared FP constants: NaN-box pattern, fflags bit positions, rounding-mode encodings
// and the packed fcsr layout.
package fp_regfile_sb_pkg;

    localparam int unsigned FLEN_SP    = 32;
    localparam logic [31:0] NAN_BOX_HI = 32'hFFFF_FFFF;

    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    typedef enum logic [2:0] {
        FrmRne = 3'd0,
        FrmRtz = 3'd1,
        FrmRdn = 3'd2,
        FrmRup = 3'd3,
        FrmRmm = 3'd4,
        FrmDyn = 3'd7
    } frm_e;

    typedef struct packed {
        logic [2:0] frm;
        logic [4:0] fflags;
    } fcsr_t;

endpackage

// File: rtl/fp_regfile_sb_if.sv
// Issue/read/write-back/CSR bundle between the FP issue stage and the register file.
interface fp_regfile_sb_if #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 3
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*FLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [FLEN-1:0]     wr_data;
    logic                wr_single;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic [AW:0]         busy_cnt;
    logic                fflags_en;
    logic [4:0]          fflags_in;
    logic                csr_we;
    logic [7:0]          csr_wdata;
    logic [7:0]          fcsr_q;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_single, iss_valid, iss_addr,
               fflags_en, fflags_in, csr_we, csr_wdata,
        input  rd_data, rd_busy, iss_ready, busy_cnt, fcsr_q
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_single, iss_valid, iss_addr,
               fflags_en, fflags_in, csr_we, csr_wdata,
        output rd_data, rd_busy, iss_ready, busy_cnt, fcsr_q
    );

endinterface

// File: rtl/fp_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per FP register plus a registered population count.
module fp_regfile_sb_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 3,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic              iss_ready_o,
    output logic [NRD-1:0]    rd_busy_o,
    output logic [AW:0]       busy_cnt_o
);
    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             iss_fire;
    logic             clr_hit;

    assign iss_ready_o = ~busy_q[iss_addr_i];
    assign iss_fire    = iss_valid_i & iss_ready_o;
    // A fired issue targets a non-busy register, so a same-address clear never decrements.
    assign clr_hit     = wr_en_i & busy_q[wr_addr_i];

    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        cnt_d = cnt_q + CW'(iss_fire) - CW'(clr_hit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd_busy
        logic [AW-1:0] addr;
        assign addr         = rd_addr_i[p*AW +: AW];
        assign rd_busy_o[p] = busy_q[addr] & ~(wr_en_i & (wr_addr_i == addr));
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file: NREGS x FLEN array with bypassed combinational reads, NaN-boxed
// write-back, pending-write scoreboard and the fcsr (frm + sticky fflags).
module fp_regfile_sb
    import fp_regfile_sb_pkg::*;
#(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 3
) (
    input logic            clk_i,
    input logic            rst_i,
    fp_regfile_sb_if.slave fp_io
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [FLEN-1:0] regs_q [NREGS];
    logic [FLEN-1:0] wr_val;
    fcsr_t           csr_q, csr_d;

    if (FLEN == 64) begin : g_nanbox
        assign wr_val = fp_io.wr_single ? {NAN_BOX_HI, fp_io.wr_data[FLEN_SP-1:0]}
                                        : fp_io.wr_data;
    end else begin : g_nobox
        logic unused_wr_single;
        assign unused_wr_single = fp_io.wr_single;
        assign wr_val           = fp_io.wr_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (fp_io.wr_en) begin
            regs_q[fp_io.wr_addr] <= wr_val;
        end
    end

    // Same-cycle write-back is forwarded in its stored (boxed) form.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = fp_io.rd_addr[p*AW +: AW];
        assign fp_io.rd_data[p*FLEN +: FLEN] =
            (fp_io.wr_en && (fp_io.wr_addr == addr)) ? wr_val : regs_q[addr];
    end

    fp_regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_addr_i   (fp_io.rd_addr),
        .wr_en_i     (fp_io.wr_en),
        .wr_addr_i   (fp_io.wr_addr),
        .iss_valid_i (fp_io.iss_valid),
        .iss_addr_i  (fp_io.iss_addr),
        .iss_ready_o (fp_io.iss_ready),
        .rd_busy_o   (fp_io.rd_busy),
        .busy_cnt_o  (fp_io.busy_cnt)
    );

    // Flags raised in a CSR-write cycle are OR-ed on top of the written value.
    always_comb begin
        csr_d = csr_q;
        if (fp_io.csr_we) begin
            csr_d = fcsr_t'(fp_io.csr_wdata);
        end
        if (fp_io.fflags_en) begin
            csr_d.fflags = csr_d.fflags | fp_io.fflags_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_q <= '0;
        end else begin
            csr_q <= csr_d;
        end
    end

    assign fp_io.fcsr_q = csr_q;

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Bench for fp_regfile_sb (FLEN=64): directed vectors, scoreboard/fcsr/reset sequences and
// random traffic against an array-based reference model.
module tb_fp_regfile_sb;
    localparam int unsigned FLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 3;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_regfile_sb_if #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD)) fp_if ();

    fp_regfile_sb #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fp_io (fp_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [FLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    logic [2:0]      m_frm;
    logic [4:0]      m_fflags;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [FLEN-1:0] data;
        logic            single;
        logic [FLEN-1:0] exp;
    } wvec_t;
    wvec_t wv [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] stored(input logic [63:0] d, input logic s);
        return s ? {32'hFFFF_FFFF, d[31:0]} : d;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < int'(NREGS); i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_frm    = '0;
        m_fflags = '0;
    endtask

    task automatic model_edge();
        bit ready;
        ready = !m_busy[fp_if.iss_addr];
        if (fp_if.wr_en) begin
            m_regs[fp_if.wr_addr] = stored(fp_if.wr_data, fp_if.wr_single);
            m_busy[fp_if.wr_addr] = 1'b0;
        end
        if (fp_if.iss_valid && ready) m_busy[fp_if.iss_addr] = 1'b1;
        if (fp_if.csr_we) begin
            m_frm    = fp_if.csr_wdata[7:5];
            m_fflags = fp_if.csr_wdata[4:0];
        end
        if (fp_if.fflags_en) m_fflags = m_fflags | fp_if.fflags_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic idle();
        fp_if.rd_addr   = '0;
        fp_if.wr_en     = 1'b0;
        fp_if.wr_addr   = '0;
        fp_if.wr_data   = '0;
        fp_if.wr_single = 1'b0;
        fp_if.iss_valid = 1'b0;
        fp_if.iss_addr  = '0;
        fp_if.fflags_en = 1'b0;
        fp_if.fflags_in = '0;
        fp_if.csr_we    = 1'b0;
        fp_if.csr_wdata = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        fp_if.rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [FLEN-1:0] rd(input int p);
        return fp_if.rd_data[p*FLEN +: FLEN];
    endfunction

    task automatic check_all(input string tag);
        for (int p = 0; p < int'(NRD); p++) begin
            logic [AW-1:0] a;
            bit            byp;
            a   = fp_if.rd_addr[p*AW +: AW];
            byp = fp_if.wr_en && (fp_if.wr_addr == a);
            chk($sformatf("%s rd_data%0d", tag, p), rd(p),
                byp ? stored(fp_if.wr_data, fp_if.wr_single) : m_regs[a]);
            chk($sformatf("%s rd_busy%0d", tag, p), 64'(fp_if.rd_busy[p]),
                64'(m_busy[a] && !byp));
        end
        chk({tag, " iss_ready"}, 64'(fp_if.iss_ready), 64'(!m_busy[fp_if.iss_addr]));
        chk({tag, " busy_cnt"}, 64'(fp_if.busy_cnt), 64'(busy_count()));
        chk({tag, " fcsr"}, 64'(fp_if.fcsr_q), 64'({m_frm, m_fflags}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FLEN-1:0] d;
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on every register and port
        for (int i = 0; i < int'(NREGS); i++) begin
            for (int p = 0; p < int'(NRD); p++) set_rd(p, AW'(i));
            #1;
            for (int p = 0; p < int'(NRD); p++) chk($sformatf("reset f%0d p%0d", i, p), rd(p), '0);
        end
        chk("reset fcsr", 64'(fp_if.fcsr_q), 64'h0);
        chk("reset busy_cnt", 64'(fp_if.busy_cnt), 64'h0);
        chk("reset iss_ready", 64'(fp_if.iss_ready), 64'h1);

        // Write vectors: bypass in the write cycle, then stored value
        wv[0] = '{5'd5,  64'h0000_0000_3F80_0000, 1'b0, 64'h0000_0000_3F80_0000};
        wv[1] = '{5'd2,  64'h0000_0000_4049_0FDB, 1'b1, 64'hFFFF_FFFF_4049_0FDB};
        wv[2] = '{5'd0,  64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
        wv[3] = '{5'd31, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0};
        for (int k = 0; k < 4; k++) begin
            idle();
            fp_if.wr_en     = 1'b1;
            fp_if.wr_addr   = wv[k].addr;
            fp_if.wr_data   = wv[k].data;
            fp_if.wr_single = wv[k].single;
            set_rd(0, wv[k].addr);
            set_rd(1, wv[k].addr);
            set_rd(2, wv[k].addr ^ 5'd1);
            #1;
            chk($sformatf("vec%0d bypass", k), rd(0), wv[k].exp);
            check_all($sformatf("vec%0d wr", k));
            tick();
            fp_if.wr_en = 1'b0;
            #1;
            chk($sformatf("vec%0d hold", k), rd(0), wv[k].exp);
            check_all($sformatf("vec%0d rd", k));
        end

        // Scoreboard: issue, clear with same-cycle rd_busy drop, swap, set-wins
        idle();
        fp_if.iss_valid = 1'b1;
        fp_if.iss_addr  = 5'd7;
        #1;
        chk("iss f7 ready", 64'(fp_if.iss_ready), 64'h1);
        tick();
        fp_if.iss_valid = 1'b0;
        set_rd(1, 5'd7);
        #1;
        chk("f7 busy ready", 64'(fp_if.iss_ready), 64'h0);
        chk("f7 rd_busy", 64'(fp_if.rd_busy[1]), 64'h1);
        chk("f7 busy_cnt", 64'(fp_if.busy_cnt), 64'h1);
        fp_if.wr_en   = 1'b1;
        fp_if.wr_addr = 5'd7;
        fp_if.wr_data = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("f7 wb rd_busy", 64'(fp_if.rd_busy[1]), 64'h0);
        chk("f7 wb no ready bypass", 64'(fp_if.iss_ready), 64'h0);
        check_all("f7 wb");
        tick();
        fp_if.wr_en = 1'b0;
        #1;
        chk("f7 cleared cnt", 64'(fp_if.busy_cnt), 64'h0);
        fp_if.iss_valid = 1'b1;
        tick();
        fp_if.iss_addr = 5'd3;
        fp_if.wr_en    = 1'b1;
        #1;
        check_all("swap");
        tick();
        idle();
        fp_if.iss_addr = 5'd3;
        #1;
        chk("swap busy_cnt", 64'(fp_if.busy_cnt), 64'h1);
        chk("swap f3 ready", 64'(fp_if.iss_ready), 64'h0);
        fp_if.iss_valid = 1'b1;
        fp_if.iss_addr  = 5'd9;
        fp_if.wr_en     = 1'b1;
        fp_if.wr_addr   = 5'd9;
        #1;
        check_all("setwins");
        tick();
        idle();
        fp_if.iss_addr = 5'd9;
        #1;
        chk("setwins ready", 64'(fp_if.iss_ready), 64'h0);
        chk("setwins busy_cnt", 64'(fp_if.busy_cnt), 64'h2);
        fp_if.wr_en   = 1'b1;
        fp_if.wr_addr = 5'd3;
        tick();
        fp_if.wr_addr = 5'd9;
        tick();
        idle();
        #1;
        check_all("drained");

        // fcsr sticky flags and CSR write with concurrent flag
        fp_if.fflags_en = 1'b1;
        fp_if.fflags_in = 5'h01;
        tick();
        fp_if.fflags_in = 5'h04;
        tick();
        idle();
        #1;
        chk("fflags NX|OF", 64'(fp_if.fcsr_q), 64'h05);
        fp_if.csr_we    = 1'b1;
        fp_if.csr_wdata = 8'h40;
        fp_if.fflags_en = 1'b1;
        fp_if.fflags_in = 5'h10;
        tick();
        idle();
        #1;
        chk("csr write + NV", 64'(fp_if.fcsr_q), 64'h50);

        // Random traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 400; n++) begin
            fp_if.wr_en     = 1'($urandom_range(0, 1));
            fp_if.wr_addr   = AW'($urandom_range(0, 7));
            fp_if.wr_data   = {$urandom, $urandom};
            fp_if.wr_single = 1'($urandom_range(0, 1));
            fp_if.iss_valid = 1'($urandom_range(0, 1));
            fp_if.iss_addr  = AW'($urandom_range(0, 7));
            for (int p = 0; p < int'(NRD); p++)
                set_rd(p, AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                         : $urandom_range(0, 7)));
            fp_if.fflags_en = ($urandom_range(0, 3) == 0);
            fp_if.fflags_in = 5'($urandom);
            fp_if.csr_we    = ($urandom_range(0, 15) == 0);
            fp_if.csr_wdata = 8'($urandom);
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        // Drain, then async reset with two pending writes
        idle();
        for (int i = 0; i < int'(NREGS); i++) begin
            if (m_busy[i]) begin
                fp_if.wr_en   = 1'b1;
                fp_if.wr_addr = AW'(i);
                tick();
            end
        end
        idle();
        fp_if.iss_valid = 1'b1;
        fp_if.iss_addr  = 5'd1;
        tick();
        fp_if.iss_addr = 5'd2;
        tick();
        idle();
        fp_if.iss_addr = 5'd1;
        set_rd(0, 5'd5);
        set_rd(1, 5'd2);
        #1;
        chk("pre-reset busy_cnt", 64'(fp_if.busy_cnt), 64'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset busy_cnt", 64'(fp_if.busy_cnt), 64'h0);
        chk("async reset ready", 64'(fp_if.iss_ready), 64'h1);
        chk("async reset f5", rd(0), '0);
        chk("async reset rd_busy", 64'(fp_if.rd_busy[1]), 64'h0);
        model_reset();
        check_all("in reset");
        tick();
        rst = 1'b0;
        d = 64'hAAAA_5555_1234_ABCD;
        fp_if.wr_en   = 1'b1;
        fp_if.wr_addr = 5'd1;
        fp_if.wr_data = d;
        #1;
        check_all("late wb");
        tick();
        idle();
        fp_if.iss_addr = 5'd1;
        set_rd(0, 5'd1);
        #1;
        chk("late wb data", rd(0), d);
        chk("late wb busy_cnt", 64'(fp_if.busy_cnt), 64'h0);
        chk("late wb ready", 64'(fp_if.iss_ready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
